// File: rtl/uart_apb_sequencer.sv
// rtl/uart_apb_sequencer.sv - APB master that configures the UART receiver and streams received bytes to the host
module uart_apb_sequencer #(
    parameter int POLL_GAP = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        stop,
    input  logic [13:0] cfg_bit_period,
    input  logic [3:0]  cfg_data_size,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [2:0]  paddr,
    output logic [7:0]  pwdata,
    input  logic [7:0]  prdata,
    input  logic        pslverr,
    output logic [7:0]  rx_byte,
    output logic [1:0]  rx_err,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        cfg_done,
    output logic        bus_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_BPL, S_WR_BPH, S_WR_DS, S_RD_STAT,
        S_RD_ERR, S_RD_DATA, S_DELIVER, S_WAIT, S_ERR
    } state_t;

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_phase;
    logic          w_phase_nxt;
    logic          w_start_ok;
    logic          w_xfer;
    logic          w_access;
    logic          w_gap_done;
    logic [GW-1:0] r_gap;
    logic [13:0]   r_bp;
    logic [3:0]    r_ds;
    logic [7:0]    r_rx_byte;
    logic [1:0]    r_rx_err;
    logic          r_bus_err;

    assign w_xfer     = r_state inside {S_WR_BPL, S_WR_BPH, S_WR_DS, S_RD_STAT, S_RD_ERR, S_RD_DATA};
    assign w_access   = w_xfer & r_phase;
    assign w_gap_done = (POLL_GAP <= 1) ? 1'b1 : (r_gap == GW'(POLL_GAP - 1));

    assign rx_byte  = r_rx_byte;
    assign rx_err   = r_rx_err;
    assign rx_valid = (r_state == S_DELIVER);
    assign cfg_done = r_state inside {S_RD_STAT, S_RD_ERR, S_RD_DATA, S_DELIVER, S_WAIT};
    assign bus_err  = r_bus_err;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = 1'b0;
        w_start_ok  = 1'b0;
        psel        = 1'b0;
        penable     = 1'b0;
        pwrite      = 1'b0;
        paddr       = 3'd0;
        pwdata      = 8'h00;
        case (r_state)
            S_IDLE, S_ERR: begin
                if (start) begin
                    w_state_nxt = S_WR_BPL;
                    w_start_ok  = 1'b1;
                end
            end
            S_DELIVER: begin
                if (rx_ready) w_state_nxt = stop ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (stop)            w_state_nxt = S_IDLE;
                else if (w_gap_done) w_state_nxt = S_RD_STAT;
            end
            default: begin
                psel        = 1'b1;
                penable     = r_phase;
                w_phase_nxt = ~r_phase;
                if (r_phase) begin
                    // A captured byte is always delivered; stop takes effect at the handshake.
                    if (pslverr)                          w_state_nxt = S_ERR;
                    else if (stop && r_state != S_RD_DATA) w_state_nxt = S_IDLE;
                    else begin
                        case (r_state)
                            S_WR_BPL:  w_state_nxt = S_WR_BPH;
                            S_WR_BPH:  w_state_nxt = S_WR_DS;
                            S_WR_DS:   w_state_nxt = S_RD_STAT;
                            S_RD_STAT: w_state_nxt = prdata[0] ? S_RD_ERR : S_WAIT;
                            S_RD_ERR:  w_state_nxt = S_RD_DATA;
                            S_RD_DATA: w_state_nxt = S_DELIVER;
                            default:   w_state_nxt = S_IDLE;
                        endcase
                    end
                end
            end
        endcase
        case (r_state)
            S_WR_BPL:  begin pwrite = 1'b1; paddr = 3'd2; pwdata = r_bp[7:0]; end
            S_WR_BPH:  begin pwrite = 1'b1; paddr = 3'd3; pwdata = {2'b00, r_bp[13:8]}; end
            S_WR_DS:   begin pwrite = 1'b1; paddr = 3'd4; pwdata = {4'h0, r_ds}; end
            S_RD_ERR:  paddr = 3'd1;
            S_RD_DATA: paddr = 3'd6;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_bp      <= '0;
            r_ds      <= '0;
            r_rx_byte <= '0;
            r_rx_err  <= '0;
            r_bus_err <= 1'b0;
            r_gap     <= '0;
        end else begin
            if (w_start_ok) begin
                r_bp <= cfg_bit_period;
                r_ds <= cfg_data_size;
            end
            if (w_start_ok)                r_bus_err <= 1'b0;
            else if (w_access && pslverr)  r_bus_err <= 1'b1;
            if (w_access && !pslverr && r_state == S_RD_ERR)  r_rx_err  <= prdata[1:0];
            if (w_access && !pslverr && r_state == S_RD_DATA) r_rx_byte <= prdata;
            if (r_state == S_WAIT && !w_gap_done) r_gap <= r_gap + 1'b1;
            else                                  r_gap <= '0;
        end
    end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// tb/tb_uart_apb_sequencer.sv - directed table-driven bench for uart_apb_sequencer
module tb_uart_apb_sequencer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start, stop;
    logic [13:0] cfg_bit_period;
    logic [3:0]  cfg_data_size;
    logic        psel, penable, pwrite;
    logic [2:0]  paddr;
    logic [7:0]  pwdata;
    logic [7:0]  prdata;
    logic        pslverr;
    logic [7:0]  rx_byte;
    logic [1:0]  rx_err;
    logic        rx_valid, rx_ready, cfg_done, bus_err;

    int n_err    = 0;
    int n_checks = 0;

    uart_apb_sequencer #(.POLL_GAP(4)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .stop(stop),
        .cfg_bit_period(cfg_bit_period), .cfg_data_size(cfg_data_size),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pslverr(pslverr),
        .rx_byte(rx_byte), .rx_err(rx_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .cfg_done(cfg_done), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    logic [16:0] w_obs;
    assign w_obs = {psel, penable, pwrite, paddr, pwdata, rx_valid, cfg_done, bus_err};

    typedef struct {
        logic        start;
        logic        stop;
        logic [7:0]  prdata;
        logic        pslverr;
        logic        rdy;
        logic [16:0] exp;
        logic [7:0]  exp_byte;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [16:0] o(input logic ps, input logic pe, input logic pw,
                                      input logic [2:0] a, input logic [7:0] d,
                                      input logic v, input logic cd, input logic be);
        return {ps, pe, pw, a, d, v, cd, be};
    endfunction

    task automatic add(input logic st, input logic sp, input logic [7:0] pd, input logic se,
                       input logic rdy, input logic [16:0] exp,
                       input logic [7:0] eb = 8'h00, input logic [1:0] ee = 2'b00);
        vec_t v;
        v.start = st; v.stop = sp; v.prdata = pd; v.pslverr = se; v.rdy = rdy;
        v.exp = exp; v.exp_byte = eb; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] pd, input logic se, input logic rdy,
                       input logic st, input logic sp);
        @(negedge clk);
        prdata = pd; pslverr = se; rx_ready = rdy; start = st; stop = sp;
        #1;
    endtask

    localparam logic [16:0] IDLE_O = 17'h0;
    localparam logic [16:0] WAIT_O = 17'h2;

    initial begin
        n_rst = 1'b0; start = 0; stop = 0; prdata = 0; pslverr = 0; rx_ready = 0;
        cfg_bit_period = 14'h0A2B; cfg_data_size = 4'd8;

        // startup config, an empty poll, a gap of 4, then a full byte poll and immediate handshake
        add(1, 0, 8'h00, 0, 0, IDLE_O);
        add(0, 0, 8'h00, 0, 0, o(1, 0, 1, 3'd2, 8'h2B, 0, 0, 0));
        add(0, 0, 8'h00, 0, 0, o(1, 1, 1, 3'd2, 8'h2B, 0, 0, 0));
        add(0, 0, 8'h00, 0, 0, o(1, 0, 1, 3'd3, 8'h0A, 0, 0, 0));
        add(0, 0, 8'h00, 0, 0, o(1, 1, 1, 3'd3, 8'h0A, 0, 0, 0));
        add(0, 0, 8'h00, 0, 0, o(1, 0, 1, 3'd4, 8'h08, 0, 0, 0));
        add(0, 0, 8'h00, 0, 0, o(1, 1, 1, 3'd4, 8'h08, 0, 0, 0));
        add(0, 0, 8'h00, 0, 0, o(1, 0, 0, 3'd0, 8'h00, 0, 1, 0));
        add(0, 0, 8'h00, 0, 0, o(1, 1, 0, 3'd0, 8'h00, 0, 1, 0));
        for (int i = 0; i < 4; i++) add(0, 0, 8'h00, 0, 0, WAIT_O);
        add(0, 0, 8'h01, 0, 0, o(1, 0, 0, 3'd0, 8'h00, 0, 1, 0));
        add(0, 0, 8'h01, 0, 0, o(1, 1, 0, 3'd0, 8'h00, 0, 1, 0));
        add(0, 0, 8'h00, 0, 0, o(1, 0, 0, 3'd1, 8'h00, 0, 1, 0));
        add(0, 0, 8'h02, 0, 0, o(1, 1, 0, 3'd1, 8'h00, 0, 1, 0));
        add(0, 0, 8'h00, 0, 0, o(1, 0, 0, 3'd6, 8'h00, 0, 1, 0));
        add(0, 0, 8'hA5, 0, 0, o(1, 1, 0, 3'd6, 8'h00, 0, 1, 0));
        add(0, 0, 8'h00, 0, 1, o(0, 0, 0, 3'd0, 8'h00, 1, 1, 0), 8'hA5, 2'b10);
        for (int i = 0; i < 4; i++) add(0, 0, 8'h00, 0, 0, WAIT_O);
        add(0, 0, 8'h01, 0, 0, o(1, 0, 0, 3'd0, 8'h00, 0, 1, 0));

        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", w_obs, IDLE_O);
        chk("reset_data", {rx_byte, rx_err}, 10'h0);
        n_rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].prdata, vecs[i].pslverr, vecs[i].rdy, vecs[i].start, vecs[i].stop);
            if (i == 1) begin
                cfg_bit_period = 14'h3FFF;
                cfg_data_size  = 4'hF;
            end
            chk($sformatf("vec%0d", i), w_obs, vecs[i].exp);
            if (vecs[i].exp[2])
                chk($sformatf("vec%0d_data", i), {rx_byte, rx_err}, {vecs[i].exp_byte, vecs[i].exp_err});
        end

        // consumer stalls for 10 cycles; start ignored, stop held but byte kept until handshake
        cyc(8'h01, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0);
        chk("rd_err_addr", w_obs, o(1, 0, 0, 3'd1, 8'h00, 0, 1, 0));
        cyc(8'h01, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0);
        cyc(8'h3C, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            cyc(8'hFF, 0, 0, k == 3, k >= 5);
            chk($sformatf("hold%0d", k), w_obs, o(0, 0, 0, 3'd0, 8'h00, 1, 1, 0));
            chk($sformatf("hold%0d_data", k), {rx_byte, rx_err}, {8'h3C, 2'b01});
        end
        cyc(8'h00, 0, 1, 0, 1);
        chk("handshake", w_obs, o(0, 0, 0, 3'd0, 8'h00, 1, 1, 0));
        cyc(8'h00, 0, 0, 0, 0);
        chk("stop_after_deliver", w_obs, IDLE_O);
        repeat (5) cyc(8'h01, 0, 0, 0, 0);
        chk("stays_idle", w_obs, IDLE_O);

        // slave error on the high bit-period write, then restart from ERR
        cfg_bit_period = 14'h1234; cfg_data_size = 4'd5;
        cyc(8'h00, 0, 0, 1, 0);
        cyc(8'h00, 0, 0, 0, 0);
        chk("err_cfg_bpl", w_obs, o(1, 0, 1, 3'd2, 8'h34, 0, 0, 0));
        cyc(8'h00, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0);
        chk("err_cfg_bph", w_obs, o(1, 0, 1, 3'd3, 8'h12, 0, 0, 0));
        cyc(8'h00, 1, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0);
        chk("err_entered", w_obs, o(0, 0, 0, 3'd0, 8'h00, 0, 0, 1));
        cyc(8'h00, 0, 0, 0, 1);
        cyc(8'h00, 0, 0, 0, 0);
        chk("err_sticky", w_obs, o(0, 0, 0, 3'd0, 8'h00, 0, 0, 1));
        cfg_bit_period = 14'h0A2B; cfg_data_size = 4'd8;
        cyc(8'h00, 0, 0, 1, 0);
        cyc(8'h00, 0, 0, 0, 0);
        chk("restart_bpl", w_obs, o(1, 0, 1, 3'd2, 8'h2B, 0, 0, 0));
        cyc(8'h00, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0);
        chk("restart_bph", w_obs, o(1, 0, 1, 3'd3, 8'h0A, 0, 0, 0));
        cyc(8'h00, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0);
        chk("restart_ds", w_obs, o(1, 0, 1, 3'd4, 8'h08, 0, 0, 0));
        cyc(8'h00, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0);
        chk("restart_poll", w_obs, o(1, 0, 0, 3'd0, 8'h00, 0, 1, 0));

        // stop at a poll boundary, then stop raised in the WR_BPH setup phase
        cyc(8'h00, 0, 0, 0, 1);
        cyc(8'h00, 0, 0, 0, 0);
        chk("stop_poll", w_obs, IDLE_O);
        cyc(8'h00, 0, 0, 1, 0);
        cyc(8'h00, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 1);
        chk("stop_bph_setup", w_obs, o(1, 0, 1, 3'd3, 8'h0A, 0, 0, 0));
        cyc(8'h00, 0, 0, 0, 1);
        chk("stop_bph_access", w_obs, o(1, 1, 1, 3'd3, 8'h0A, 0, 0, 0));
        cyc(8'h00, 0, 0, 0, 0);
        chk("stop_bph_idle", w_obs, IDLE_O);

        // asynchronous reset during an access phase
        cyc(8'h00, 0, 0, 1, 0);
        cyc(8'h00, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0);
        chk("pre_reset_access", w_obs, o(1, 1, 1, 3'd2, 8'h2B, 0, 0, 0));
        n_rst = 1'b0;
        #1;
        chk("async_reset", w_obs, IDLE_O);
        chk("async_reset_data", {rx_byte, rx_err}, 10'h0);
        @(negedge clk);
        n_rst = 1'b1;
        cyc(8'h00, 0, 0, 0, 0);
        chk("post_reset", w_obs, IDLE_O);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
